// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage feeding decode_stage. Owns the fetch PC, keeps a
// single request outstanding to instruction memory, buffers returned words in
// a two-entry queue and presents the head entry on DE_NPC / DE_IR / DE_V.
// Taken branches or jumps resolved in execute redirect the PC and flush the
// queue. A request that is still in flight when a redirect arrives has its
// response drained and discarded.
//
// Optional build macro: FETCH_JAL_PREDICT_EN
//   defined   - a fetched JAL (opcode 7'b1101111) steers the next fetch to its
//               target, and the queued entry carries DE_PRED=1.
//   undefined - fetch is purely sequential and DE_PRED is always 0.
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        STALL,
   input  logic        BR_TAKEN,
   input  logic [63:0] BR_TARGET,
   output logic        IMEM_REQ,
   output logic [63:0] IMEM_ADDR,
   input  logic        IMEM_RDY,
   input  logic [31:0] IMEM_DATA,
   output logic [63:0] DE_NPC,
   output logic [31:0] DE_IR,
   output logic        DE_V,
   output logic        DE_PRED
);

   typedef enum logic [1:0] {
      FETCH_IDLE  = 2'd0,
      FETCH_REQ   = 2'd1,
      FETCH_DRAIN = 2'd2
   } fetchState_e;

   // Fetch control state
   fetchState_e state_q;
   fetchState_e state_d;
   logic [63:0] pc_q;
   logic [63:0] pc_d;
   logic        imemReq_q;
   logic [63:0] imemAddr_q;

   // Instruction queue storage; pointers are one bit wide because the queue
   // holds exactly two entries
   logic [63:0] qNpc_q  [BUF_DEPTH];
   logic [31:0] qIr_q   [BUF_DEPTH];
   logic        qPred_q [BUF_DEPTH];
   logic        rdPtr_q;
   logic        wrPtr_q;
   logic [1:0]  count_q;

   // Per-cycle handshake decisions
   logic        push;
   logic        pop;
   logic [1:0]  countNext;
   logic        slotFree;
   logic [63:0] redirectPc;
   logic [63:0] seqPc;
   logic        pushPred;
   logic [1:0]  unusedTgtBits;

   // A response is only accepted into the queue while a request is live and
   // no redirect is happening; a redirect turns that response into garbage.
   assign push = (state_q == FETCH_REQ) && IMEM_RDY && !BR_TAKEN;

   // Decode consumes the head whenever it is valid and not stalled. Under a
   // redirect the whole queue is flushed, so no separate pop is needed.
   assign pop = (count_q != 2'd0) && !STALL && !BR_TAKEN;

   // Occupancy after this cycle's push and pop, used to decide whether the
   // FSM may issue another request.
   assign countNext = count_q + {1'b0, push} - {1'b0, pop};
   assign slotFree  = (countNext < 2'(BUF_DEPTH));

   // Redirect targets are forced onto a word boundary; the low bits are
   // deliberately ignored.
   assign redirectPc    = {BR_TARGET[63:2], 2'b00};
   assign unusedTgtBits = BR_TARGET[1:0];

`ifdef FETCH_JAL_PREDICT_EN
   logic        isJal;
   logic [63:0] jImm;

   // JAL is always taken, so fetch can follow it without waiting for execute.
   assign isJal    = (IMEM_DATA[6:0] == 7'b1101111);
   assign jImm     = {{44{IMEM_DATA[31]}}, IMEM_DATA[19:12], IMEM_DATA[20],
                      IMEM_DATA[30:21], 1'b0};
   assign pushPred = isJal;
   assign seqPc    = isJal ? ((pc_q + jImm) & ~64'h3) : (pc_q + 64'd4);
`else
   assign pushPred = 1'b0;
   assign seqPc    = pc_q + 64'd4;
`endif

   // Next-state and next-PC selection; redirect outranks everything else,
   // and an accepted response advances the PC.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;

      if (BR_TAKEN) begin
         pc_d = redirectPc;
      end else if (push) begin
         pc_d = seqPc;
      end

      case (state_q)
         FETCH_IDLE: begin
            if (BR_TAKEN || slotFree) begin
               state_d = FETCH_REQ;
            end
         end
         FETCH_REQ: begin
            if (BR_TAKEN) begin
               state_d = IMEM_RDY ? FETCH_REQ : FETCH_DRAIN;
            end else if (IMEM_RDY) begin
               state_d = slotFree ? FETCH_REQ : FETCH_IDLE;
            end
         end
         FETCH_DRAIN: begin
            if (IMEM_RDY) begin
               state_d = FETCH_REQ;
            end
         end
         default: begin
            state_d = FETCH_IDLE;
         end
      endcase
   end

   // Fetch FSM with registered memory-request outputs; the request address
   // is held at the PC until the response arrives.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= FETCH_IDLE;
         pc_q       <= {RESET_PC[63:2], 2'b00};
         imemReq_q  <= 1'b0;
         imemAddr_q <= 64'h0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         imemReq_q  <= (state_d == FETCH_REQ);
         imemAddr_q <= (state_d == FETCH_REQ) ? pc_d : 64'h0;
      end
   end

   // Two-entry instruction queue: write at wrPtr, read at rdPtr, flushed by
   // a redirect.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < int'(BUF_DEPTH); i++) begin
            qNpc_q[i]  <= 64'h0;
            qIr_q[i]   <= 32'h0;
            qPred_q[i] <= 1'b0;
         end
         rdPtr_q <= 1'b0;
         wrPtr_q <= 1'b0;
         count_q <= 2'd0;
      end else if (BR_TAKEN) begin
         rdPtr_q <= 1'b0;
         wrPtr_q <= 1'b0;
         count_q <= 2'd0;
      end else begin
         if (push) begin
            qNpc_q[wrPtr_q]  <= pc_q;
            qIr_q[wrPtr_q]   <= IMEM_DATA;
            qPred_q[wrPtr_q] <= pushPred;
            wrPtr_q          <= ~wrPtr_q;
         end
         if (pop) begin
            rdPtr_q <= ~rdPtr_q;
         end
         count_q <= countNext;
      end
   end

   assign IMEM_REQ  = imemReq_q;
   assign IMEM_ADDR = imemAddr_q;

   assign DE_V    = (count_q != 2'd0);
   assign DE_NPC  = qNpc_q[rdPtr_q];
   assign DE_IR   = qIr_q[rdPtr_q];
   assign DE_PRED = qPred_q[rdPtr_q];

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. A memory responder model answers requests
// after a programmable latency. Stimulus pushes the instructions that decode
// is expected to consume into a scoreboard queue; a monitor pops and compares
// whenever decode accepts an instruction. Timing-specific behaviour (request
// address, stall hold, redirect) is checked directly at chosen cycles.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   logic        CLK;
   logic        RESET;
   logic        STALL;
   logic        BR_TAKEN;
   logic [63:0] BR_TARGET;
   logic        IMEM_REQ;
   logic [63:0] IMEM_ADDR;
   logic        IMEM_RDY;
   logic [31:0] IMEM_DATA;
   logic [63:0] DE_NPC;
   logic [31:0] DE_IR;
   logic        DE_V;
   logic        DE_PRED;

   typedef struct packed {
      logic [63:0] npc;
      logic [31:0] ir;
      logic        pred;
   } expEntry_t;

   expEntry_t expQ[$];

   int checkCount = 0;
   int passCount  = 0;
   int cyc        = 0;

   int          memLat  = 1;
   bit          jalMode = 1'b0;
   logic        memBusy;
   int          memCnt;
   logic [63:0] memAddr;

   localparam logic [31:0] JAL_PLUS16 = 32'h0100006F;

`ifdef FETCH_JAL_PREDICT_EN
   localparam bit          PREDICT   = 1'b1;
   localparam logic [63:0] AFTER_JAL = 64'h30;
`else
   localparam bit          PREDICT   = 1'b0;
   localparam logic [63:0] AFTER_JAL = 64'h24;
`endif

   fetch_stage #(
      .RESET_PC  (64'h0),
      .BUF_DEPTH (2)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .STALL     (STALL),
      .BR_TAKEN  (BR_TAKEN),
      .BR_TARGET (BR_TARGET),
      .IMEM_REQ  (IMEM_REQ),
      .IMEM_ADDR (IMEM_ADDR),
      .IMEM_RDY  (IMEM_RDY),
      .IMEM_DATA (IMEM_DATA),
      .DE_NPC    (DE_NPC),
      .DE_IR     (DE_IR),
      .DE_V      (DE_V),
      .DE_PRED   (DE_PRED)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Memory contents: an addi whose immediate encodes the address, so every
   // word is distinguishable; optionally a JAL +16 at 0x20.
   function automatic logic [31:0] memWord(input logic [63:0] a);
      if (jalMode && (a == 64'h20)) begin
         return JAL_PLUS16;
      end
      return {a[13:2], 20'h00013};
   endfunction

   // Memory responder: latches a request, answers memLat cycles later for one
   // cycle, and ignores the request that is still held during that cycle.
   initial begin
      IMEM_RDY  = 1'b0;
      IMEM_DATA = 32'h0;
      memBusy   = 1'b0;
      memCnt    = 0;
      memAddr   = 64'h0;
   end

   always @(posedge CLK) begin
      if (RESET !== 1'b1) begin
         IMEM_RDY <= 1'b0;
         memBusy  <= 1'b0;
         memCnt   <= 0;
      end else if (IMEM_RDY) begin
         IMEM_RDY <= 1'b0;
         memBusy  <= 1'b0;
      end else if (memBusy) begin
         if (memCnt <= 1) begin
            IMEM_RDY  <= 1'b1;
            IMEM_DATA <= memWord(memAddr);
         end else begin
            memCnt <= memCnt - 1;
         end
      end else if (IMEM_REQ === 1'b1) begin
         memBusy <= 1'b1;
         memAddr <= IMEM_ADDR;
         if (memLat <= 1) begin
            IMEM_RDY  <= 1'b1;
            IMEM_DATA <= memWord(IMEM_ADDR);
         end else begin
            memCnt <= memLat - 1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h",
                  name, cyc, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic stall, input logic br,
                                input logic [63:0] target);
      STALL     = stall;
      BR_TAKEN  = br;
      BR_TARGET = target;
   endtask

   task automatic expectInstr(input logic [63:0] npc, input logic [31:0] ir,
                              input logic pred);
      expEntry_t e;
      e.npc  = npc;
      e.ir   = ir;
      e.pred = pred;
      expQ.push_back(e);
   endtask

   task automatic goTo(input int n);
      while (cyc < n) begin
         @(posedge CLK);
         #1;
         cyc++;
      end
   endtask

   task automatic holdReset(input int lat, input bit jal);
      RESET = 1'b0;
      applyStimulus(1'b0, 1'b0, 64'h0);
      memLat  = lat;
      jalMode = jal;
      repeat (3) @(posedge CLK);
      #1;
   endtask

   task automatic releaseReset();
      RESET = 1'b1;
      cyc   = 0;
   endtask

   // Monitor: every instruction decode accepts must match the scoreboard head
   always @(negedge CLK) begin
      expEntry_t e;
      if ((RESET === 1'b1) && (DE_V === 1'b1) && (STALL === 1'b0) &&
          (BR_TAKEN === 1'b0)) begin
         if (expQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL unexpectedInstr at cycle %0d: got npc %h ir %h, expected none",
                     cyc, DE_NPC, DE_IR);
         end else begin
            e = expQ.pop_front();
            checkOutput("deNpc", DE_NPC, e.npc);
            checkOutput("deIr", {32'h0, DE_IR}, {32'h0, e.ir});
            checkOutput("dePred", {63'h0, DE_PRED}, {63'h0, e.pred});
         end
      end
   end

   // Directed phases, each starting from a fresh reset
   initial begin
      RESET = 1'b0;
      applyStimulus(1'b0, 1'b0, 64'h0);

      // Reset values, then sequential fetch with a stall that fills the queue
      holdReset(1, 1'b0);
      checkOutput("rstReq", {63'h0, IMEM_REQ}, 64'h0);
      checkOutput("rstAddr", IMEM_ADDR, 64'h0);
      checkOutput("rstDeV", {63'h0, DE_V}, 64'h0);
      checkOutput("rstDeIr", {32'h0, DE_IR}, 64'h0);
      checkOutput("rstDeNpc", DE_NPC, 64'h0);
      checkOutput("rstDePred", {63'h0, DE_PRED}, 64'h0);
      for (int a = 0; a <= 16; a += 4) begin
         expectInstr(64'(a), memWord(64'(a)), 1'b0);
      end
      releaseReset();
      checkOutput("idleAfterRelease", {63'h0, IMEM_REQ}, 64'h0);
      goTo(1);
      checkOutput("firstReq", {63'h0, IMEM_REQ}, 64'h1);
      checkOutput("firstAddr", IMEM_ADDR, 64'h0);
      checkOutput("noDataYet", {63'h0, DE_V}, 64'h0);
      goTo(2);
      checkOutput("reqHeld", {63'h0, IMEM_REQ}, 64'h1);
      checkOutput("addrHeld", IMEM_ADDR, 64'h0);
      goTo(3);
      checkOutput("deVRise", {63'h0, DE_V}, 64'h1);
      checkOutput("firstNpc", DE_NPC, 64'h0);
      checkOutput("secondAddr", IMEM_ADDR, 64'h4);
      goTo(8);
      applyStimulus(1'b1, 1'b0, 64'h0);
      goTo(9);
      checkOutput("stallNpc", DE_NPC, 64'hC);
      checkOutput("stallIr", {32'h0, DE_IR}, {32'h0, memWord(64'hC)});
      goTo(11);
      checkOutput("fullReqDrop", {63'h0, IMEM_REQ}, 64'h0);
      checkOutput("stallHoldV", {63'h0, DE_V}, 64'h1);
      checkOutput("stallHoldNpc", DE_NPC, 64'hC);
      checkOutput("stallHoldIr", {32'h0, DE_IR}, {32'h0, memWord(64'hC)});
      goTo(12);
      checkOutput("fullReqLow", {63'h0, IMEM_REQ}, 64'h0);
      checkOutput("stallHoldNpc2", DE_NPC, 64'hC);
      goTo(13);
      applyStimulus(1'b0, 1'b0, 64'h0);
      goTo(14);
      checkOutput("resumeReq", {63'h0, IMEM_REQ}, 64'h1);
      checkOutput("resumeAddr", IMEM_ADDR, 64'h14);
      checkOutput("resumeNpc", DE_NPC, 64'h10);
      goTo(15);
      applyStimulus(1'b1, 1'b0, 64'h0);
      goTo(16);
      checkOutput("drainedSeq", 64'(expQ.size()), 64'h0);
      RESET = 1'b0;
      #1;
      checkOutput("asyncRstReq", {63'h0, IMEM_REQ}, 64'h0);
      checkOutput("asyncRstDeV", {63'h0, DE_V}, 64'h0);
      checkOutput("asyncRstAddr", IMEM_ADDR, 64'h0);

      // Redirect one cycle after a request with 3-cycle memory
      holdReset(3, 1'b0);
      expectInstr(64'h0, memWord(64'h0), 1'b0);
      expectInstr(64'h1000, memWord(64'h1000), 1'b0);
      releaseReset();
      goTo(6);
      applyStimulus(1'b0, 1'b1, 64'h1002);
      goTo(7);
      applyStimulus(1'b0, 1'b0, 64'h0);
      checkOutput("drainNoReq", {63'h0, IMEM_REQ}, 64'h0);
      goTo(8);
      checkOutput("drainNoReq2", {63'h0, IMEM_REQ}, 64'h0);
      checkOutput("drainNoData", {63'h0, DE_V}, 64'h0);
      goTo(9);
      checkOutput("targetReq", {63'h0, IMEM_REQ}, 64'h1);
      checkOutput("targetAddr", IMEM_ADDR, 64'h1000);
      goTo(14);
      applyStimulus(1'b1, 1'b0, 64'h0);
      goTo(16);
      checkOutput("drainedRedirect", 64'(expQ.size()), 64'h0);

      // Redirect coincident with a response while decode is stalled
      holdReset(1, 1'b0);
      expectInstr(64'h2000, memWord(64'h2000), 1'b0);
      releaseReset();
      goTo(3);
      applyStimulus(1'b1, 1'b0, 64'h0);
      goTo(4);
      checkOutput("stalledHead", DE_NPC, 64'h0);
      applyStimulus(1'b1, 1'b1, 64'h2000);
      goTo(5);
      applyStimulus(1'b0, 1'b0, 64'h0);
      checkOutput("flushDeV", {63'h0, DE_V}, 64'h0);
      checkOutput("rdyBrReq", {63'h0, IMEM_REQ}, 64'h1);
      checkOutput("rdyBrAddr", IMEM_ADDR, 64'h2000);
      goTo(8);
      applyStimulus(1'b1, 1'b0, 64'h0);
      goTo(9);
      checkOutput("drainedRdyBr", 64'(expQ.size()), 64'h0);

      // PC wrap at the top of the address space
      holdReset(1, 1'b0);
      expectInstr(64'hFFFF_FFFF_FFFF_FFFC, memWord(64'hFFFF_FFFF_FFFF_FFFC), 1'b0);
      expectInstr(64'h0, memWord(64'h0), 1'b0);
      releaseReset();
      applyStimulus(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      goTo(1);
      applyStimulus(1'b0, 1'b0, 64'h0);
      checkOutput("topReq", {63'h0, IMEM_REQ}, 64'h1);
      checkOutput("topAddr", IMEM_ADDR, 64'hFFFF_FFFF_FFFF_FFFC);
      goTo(3);
      checkOutput("wrapAddr", IMEM_ADDR, 64'h0);
      checkOutput("wrapNpc", DE_NPC, 64'hFFFF_FFFF_FFFF_FFFC);
      goTo(6);
      applyStimulus(1'b1, 1'b0, 64'h0);
      goTo(7);
      checkOutput("drainedWrap", 64'(expQ.size()), 64'h0);

      // JAL +16 at 0x20: followed when prediction is built in, else sequential
      holdReset(1, 1'b1);
      expectInstr(64'h20, JAL_PLUS16, PREDICT);
      expectInstr(AFTER_JAL, memWord(AFTER_JAL), 1'b0);
      releaseReset();
      applyStimulus(1'b0, 1'b1, 64'h20);
      goTo(1);
      applyStimulus(1'b0, 1'b0, 64'h0);
      checkOutput("jalFetchAddr", IMEM_ADDR, 64'h20);
      goTo(3);
      checkOutput("afterJalAddr", IMEM_ADDR, AFTER_JAL);
      checkOutput("jalNpc", DE_NPC, 64'h20);
      checkOutput("jalPred", {63'h0, DE_PRED}, {63'h0, PREDICT});
      goTo(6);
      applyStimulus(1'b1, 1'b0, 64'h0);
      goTo(7);
      checkOutput("drainedJal", 64'(expQ.size()), 64'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   // Safety net so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
